dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have parameter DW, default 8: data bus width in bits.
REQ-002 SHALL have parameter AW, default 8: address bus width in bits.
REQ-003 SHALL have parameter NCH, default 2: number of independent channels (1..8).
REQ-004 SHALL have parameter BURST, default 4: maximum words moved per bus tenure (>=1).
REQ-005 SHALL have port clock, input, 1: single system clock; all logic on the rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, NCH: one-cycle start pulse per channel.
REQ-008 SHALL have port src, input, NCH*AW: per-channel source base address, sampled at start.
REQ-009 SHALL have port dst, input, NCH*AW: per-channel destination base address, sampled at start.
REQ-010 SHALL have port len, input, NCH*AW: per-channel word count, sampled at start.
REQ-011 SHALL have port HLDR, output, 1: bus hold request to the CPU.
REQ-012 SHALL have port HLDA, input, 1: bus hold acknowledge from the CPU.
REQ-013 SHALL have port AB, output, AW: memory address.
REQ-014 SHALL have port DB_out, output, DW: memory write data.
REQ-015 SHALL have port DB_in, input, DW: memory read data, valid one cycle after the read strobe.
REQ-016 SHALL have port rd, output, 1: memory read strobe.
REQ-017 SHALL have port we, output, 1: memory write strobe.
REQ-018 SHALL have port busy, output, NCH: channel holds a pending or active transfer.
REQ-019 SHALL have port done, output, NCH: one-cycle completion pulse per channel.

Function
REQ-020 All outputs SHALL be registered; AB, DB_out, rd, and we are meaningful only while HLDR=1 and HLDA=1.
REQ-021 A start pulse on an idle channel SHALL latch src, dst, and len, clear the word index, and set busy the next cycle.
REQ-022 A start pulse on a busy channel SHALL be ignored.
REQ-023 A start with len=0 SHALL produce a done pulse one cycle later, leave busy low, and never assert HLDR.
REQ-024 The FSM SHALL have the states IDLE, REQ, READ, WRITE, and GAP.
REQ-025 In IDLE with any busy channel, the FSM SHALL select one channel round-robin (lowest index after the last served), assert HLDR, and go to REQ.
REQ-026 In REQ, the FSM SHALL hold HLDR=1 and wait until HLDA=1, then go to READ.
REQ-027 In READ, the FSM SHALL drive AB=src+idx and rd=1 for one cycle, then go to WRITE.
REQ-028 In WRITE, the FSM SHALL drive AB=dst+idx, DB_out=DB_in, and we=1 for one cycle, and increment idx.
REQ-029 Each word SHALL take exactly 2 cycles.
REQ-030 Address sums SHALL wrap modulo 2^AW.
REQ-031 After WRITE, if idx equals len, the FSM SHALL pulse done, clear busy, drop HLDR, and go to GAP.
REQ-032 After WRITE, if BURST words have been moved in this tenure, or HLDA=0, the FSM SHALL drop HLDR, keep the channel busy with idx retained, and go to GAP.
REQ-033 Otherwise after WRITE, the FSM SHALL go to READ.
REQ-034 GAP SHALL last exactly one cycle with HLDR=0, then go to IDLE; this guarantees the CPU one bus cycle between tenures.
REQ-035 If HLDA falls during READ, the word in flight SHALL still complete its WRITE before release; a word SHALL never be split.
REQ-036 A start arriving in the same cycle as done on the same channel SHALL be ignored.
REQ-037 A start arriving in the same cycle as done on a different channel SHALL be accepted.
REQ-038 rd and we SHALL never be high in the same cycle.

Reset
REQ-039 While reset_n=0, asynchronously: FSM=IDLE, HLDR=0, rd=0, we=0, AB=0, DB_out=0, busy=0, done=0, round-robin pointer=channel 0, and all latched src/dst/len/idx=0.
REQ-040 A reset mid-transfer SHALL abort all channels; no done pulse SHALL be issued for aborted transfers.

Verification
REQ-041 Ch0 start src=0x10 dst=0x40 len=3, HLDA tied to HLDR with 1-cycle delay -> reads 0x10..0x12 and writes 0x40..0x42 in order, done[0] pulses once, HLDR drops, 6 data cycles total.
REQ-042 Ch0 len=6, BURST=4 -> 4 words, HLDR low for exactly 1 GAP cycle, re-request, 2 words, then done[0].
REQ-043 Ch0 and ch1 started in the same cycle, each len=8, BURST=4 -> tenures alternate ch0, ch1, ch0, ch1; both done pulses occur.
REQ-044 HLDA dropped during a READ cycle -> that word's write completes, HLDR falls, and after HLDA returns the transfer resumes at the next idx with no duplicated or skipped address.
REQ-045 src=0xFE len=4, AW=8 -> reads 0xFE, 0xFF, 0x00, 0x01; start with len=0 -> done pulse one cycle later, HLDR stays 0.
REQ-046 reset_n asserted in WRITE of word 2 of 5 -> all outputs 0 immediately, no done pulse; a new start after reset_n deasserts runs normally from idx 0.

Source files
------------

// File: rtl/dma_controller.sv
// Multi-channel DMA controller: borrows the bus via HLDR/HLDA, serves busy channels
// round-robin, moves one word per READ/WRITE pair and at most BURST words per tenure.

module dma_channel #(
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic          blocked_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [AW-1:0] len_i,
    input  logic          inc_i,
    input  logic          fin_i,
    output logic          busy_o,
    output logic          zero_o,
    output logic [AW-1:0] src_o,
    output logic [AW-1:0] dst_o,
    output logic [AW-1:0] len_o,
    output logic [AW-1:0] idx_o
);
    logic          busy_q;
    logic [AW-1:0] src_q, dst_q, len_q, idx_q;
    logic          accept;

    // blocked_i covers a start landing in the same cycle as this channel's done pulse
    assign accept = start_i && !busy_q && !blocked_i;
    assign zero_o = accept && (len_i == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            busy_q <= (len_i != '0);
            src_q  <= src_i;
            dst_q  <= dst_i;
            len_q  <= len_i;
            idx_q  <= '0;
        end else begin
            if (inc_i) idx_q <= idx_q + AW'(1);
            if (fin_i) busy_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign len_o  = len_q;
    assign idx_o  = idx_q;
endmodule

module dma_controller #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int NCH   = 2,
    parameter int BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NCH-1:0]    start,
    input  logic [NCH*AW-1:0] src,
    input  logic [NCH*AW-1:0] dst,
    input  logic [NCH*AW-1:0] len,
    output logic              HLDR,
    input  logic              HLDA,
    output logic [AW-1:0]     AB,
    output logic [DW-1:0]     DB_out,
    input  logic [DW-1:0]     DB_in,
    output logic              rd,
    output logic              we,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(BURST + 1);

    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, GAP} state_e;

    state_e         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d, rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hldr_q, hldr_d, rd_q, rd_d, we_q, we_d;
    logic [AW-1:0]  ab_q, ab_d;
    logic [DW-1:0]  db_q, db_d;
    logic [NCH-1:0] done_q, done_d;

    logic [NCH-1:0][AW-1:0] src_c, dst_c, len_c, idx_c;
    logic [NCH-1:0]         busy_c, zero_c, inc_c, fin_c;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dma_channel #(.AW(AW)) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .start_i   (start[g]),
            .blocked_i (done_q[g]),
            .src_i     (src[g*AW +: AW]),
            .dst_i     (dst[g*AW +: AW]),
            .len_i     (len[g*AW +: AW]),
            .inc_i     (inc_c[g]),
            .fin_i     (fin_c[g]),
            .busy_o    (busy_c[g]),
            .zero_o    (zero_c[g]),
            .src_o     (src_c[g]),
            .dst_o     (dst_c[g]),
            .len_o     (len_c[g]),
            .idx_o     (idx_c[g])
        );
    end

    logic [AW-1:0]  idx_nx;
    logic           last_w, burst_end, rel;
    logic           pick_vld;
    logic [CHW-1:0] pick, cand;

    assign idx_nx    = idx_c[ch_q] + AW'(1);
    assign last_w    = (idx_nx == len_c[ch_q]);
    assign burst_end = (cnt_q == CW'(BURST - 1));
    assign rel       = last_w || burst_end || !HLDA;

    // rr_q names the first channel to consider; it moves past whichever channel wins
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CHW'((int'(rr_q) + i) % NCH);
            if (!pick_vld && busy_c[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            hldr_q  <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            ab_q    <= '0;
            db_q    <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            hldr_q  <= hldr_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ab_q    <= ab_d;
            db_q    <= db_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (pick_vld) begin
                state_d = REQ;
                ch_d    = pick;
                rr_d    = CHW'((int'(pick) + 1) % NCH);
                cnt_d   = '0;
            end
            REQ:   if (HLDA) state_d = READ;
            READ:  state_d = WRITE;
            WRITE: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = rel ? GAP : READ;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so the registered strobes line
    // up with the state; DB_in is captured on the edge that closes the READ cycle.
    always_comb begin
        hldr_d = 1'b0;
        rd_d   = 1'b0;
        we_d   = 1'b0;
        ab_d   = '0;
        db_d   = '0;
        inc_c  = '0;
        fin_c  = '0;
        case (state_q)
            IDLE, GAP: hldr_d = |busy_c;
            REQ: begin
                hldr_d = 1'b1;
                if (HLDA) begin
                    rd_d = 1'b1;
                    ab_d = src_c[ch_q] + idx_c[ch_q];
                end
            end
            READ: begin
                hldr_d = 1'b1;
                we_d   = 1'b1;
                ab_d   = dst_c[ch_q] + idx_c[ch_q];
                db_d   = DB_in;
            end
            WRITE: begin
                inc_c[ch_q] = 1'b1;
                fin_c[ch_q] = last_w;
                if (!rel) begin
                    hldr_d = 1'b1;
                    rd_d   = 1'b1;
                    ab_d   = src_c[ch_q] + idx_nx;
                end
            end
            default: hldr_d = 1'b0;
        endcase
        done_d = zero_c | fin_c;
    end

    assign HLDR   = hldr_q;
    assign rd     = rd_q;
    assign we     = we_q;
    assign AB     = ab_q;
    assign DB_out = db_q;
    assign busy   = busy_c;
    assign done   = done_q;
endmodule

// File: tb/tb_dma_controller.sv
// Directed-random bench for dma_controller: a word-level reference model predicts the
// read/write address streams, data and tenure sizes, compared against a bus monitor.

module tb_dma_controller;
    localparam int DW = 8, AW = 8, NCH = 2, BURST = 4;
    localparam int MSZ = 1 << AW;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [NCH-1:0]    start = '0;
    logic [NCH*AW-1:0] src = '0, dst = '0, len = '0;
    logic              HLDR, HLDA, rd, we;
    logic [AW-1:0]     AB;
    logic [DW-1:0]     DB_out, DB_in;
    logic [NCH-1:0]    busy, done;

    logic [DW-1:0] rom [0:MSZ-1];
    logic hlda_pipe = 1'b0, hlda_off = 1'b0;

    dma_controller #(.DW(DW), .AW(AW), .NCH(NCH), .BURST(BURST)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .src(src), .dst(dst), .len(len),
        .HLDR(HLDR), .HLDA(HLDA), .AB(AB), .DB_out(DB_out), .DB_in(DB_in),
        .rd(rd), .we(we), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // CPU grants the bus one cycle after the request; hlda_off lets a step revoke it
    always @(posedge clock) hlda_pipe <= HLDR;
    assign HLDA  = hlda_pipe & ~hlda_off;
    assign DB_in = rom[AB];

    int errors = 0, checks = 0;
    int rd_log[$], wa_log[$], wd_log[$], ten_log[$], gap_log[$];
    int exp_rd[$], exp_wa[$], exp_wd[$], exp_ten[$];
    int done_cnt[NCH];
    int overlap = 0, data_cyc = 0, run_w = 0, low_run = 0;
    bit seen_ten = 0;
    int m_src[NCH], m_dst[NCH], m_len[NCH];

    always @(negedge clock) begin
        if (rd) rd_log.push_back(int'(AB));
        if (we) begin
            wa_log.push_back(int'(AB));
            wd_log.push_back(int'(DB_out));
        end
        if (rd && we) overlap++;
        if (rd || we) data_cyc++;
        for (int c = 0; c < NCH; c++) if (done[c]) done_cnt[c]++;
        if (HLDR) begin
            if (low_run > 0 && seen_ten) gap_log.push_back(low_run);
            low_run = 0;
            if (we) run_w++;
        end else begin
            if (run_w > 0) begin
                ten_log.push_back(run_w);
                seen_ten = 1;
            end
            run_w = 0;
            low_run++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete(); ten_log.delete(); gap_log.delete();
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_ten.delete();
        for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
        data_cyc = 0; run_w = 0; low_run = 0; seen_ten = 0;
    endtask

    task automatic set_ch(int c, int s, int d, int l);
        src[c*AW +: AW] = AW'(s);
        dst[c*AW +: AW] = AW'(d);
        len[c*AW +: AW] = AW'(l);
    endtask

    task automatic mdl(int c, int s, int d, int l);
        m_src[c] = s; m_dst[c] = d; m_len[c] = l;
    endtask

    task automatic pulse(logic [NCH-1:0] m);
        start = m;
        tick();
        start = '0;
    endtask

    // Word-level prediction: channels in mask start together from an idle, freshly
    // reset controller; tenures rotate round-robin from channel 0, BURST words each.
    task automatic model_run(logic [NCH-1:0] mask);
        int rem[NCH];
        int pos[NCH];
        int ptr, pick, k, a;
        ptr = 0;
        for (int c = 0; c < NCH; c++) begin
            rem[c] = mask[c] ? m_len[c] : 0;
            pos[c] = 0;
        end
        for (int guard = 0; guard < 256; guard++) begin
            pick = -1;
            for (int i = 0; i < NCH; i++)
                if (pick < 0 && rem[(ptr + i) % NCH] > 0) pick = (ptr + i) % NCH;
            if (pick < 0) break;
            k = (rem[pick] < BURST) ? rem[pick] : BURST;
            for (int j = 0; j < k; j++) begin
                a = (m_src[pick] + pos[pick]) % MSZ;
                exp_rd.push_back(a);
                exp_wa.push_back((m_dst[pick] + pos[pick]) % MSZ);
                exp_wd.push_back(int'(rom[a]));
                pos[pick]++;
            end
            rem[pick] -= k;
            exp_ten.push_back(k);
            ptr = (pick + 1) % NCH;
        end
    endtask

    task automatic cmp_logs(string tag, bit with_ten);
        int n;
        chk({tag, "/nrd"}, rd_log.size(), exp_rd.size());
        chk({tag, "/nwr"}, wa_log.size(), exp_wa.size());
        n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s/rd%0d", tag, i), rd_log[i], exp_rd[i]);
        n = (wa_log.size() < exp_wa.size()) ? wa_log.size() : exp_wa.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/wa%0d", tag, i), wa_log[i], exp_wa[i]);
            chk($sformatf("%s/wd%0d", tag, i), wd_log[i], exp_wd[i]);
        end
        if (with_ten) begin
            chk({tag, "/nten"}, ten_log.size(), exp_ten.size());
            n = (ten_log.size() < exp_ten.size()) ? ten_log.size() : exp_ten.size();
            for (int i = 0; i < n; i++) chk($sformatf("%s/ten%0d", tag, i), ten_log[i], exp_ten[i]);
        end
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "/HLDR"}, int'(HLDR), 0);
        chk({tag, "/rd"}, int'(rd), 0);
        chk({tag, "/we"}, int'(we), 0);
        chk({tag, "/AB"}, int'(AB), 0);
        chk({tag, "/DB_out"}, int'(DB_out), 0);
        chk({tag, "/busy"}, int'(busy), 0);
        chk({tag, "/done"}, int'(done), 0);
    endtask

    task automatic do_reset(string tag);
        start = '0; hlda_off = 0; reset_n = 0;
        tick();
        chk_quiet({tag, "/rst"});
        reset_n = 1;
        tick();
        clear_logs();
    endtask

    task automatic wait_idle(string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy == '0 && !HLDR) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk({tag, "/idle_timeout"}, int'(ok), 1);
        repeat (3) tick();
    endtask

    initial begin
        int s, d, l;
        int wrapx[4];
        bit ok;
        wrapx = '{'hFE, 'hFF, 'h00, 'h01};
        for (int i = 0; i < MSZ; i++) rom[i] = DW'($urandom);

        // single short transfer, fixed addresses
        do_reset("s1");
        set_ch(0, 'h10, 'h40, 3); mdl(0, 'h10, 'h40, 3); model_run(2'b01);
        pulse(2'b01);
        chk("s1/busy_set", int'(busy), 1);
        wait_idle("s1");
        cmp_logs("s1", 1);
        chk("s1/done0", done_cnt[0], 1);
        chk("s1/data_cycles", data_cyc, 6);
        chk("s1/hldr_end", int'(HLDR), 0);

        // length beyond BURST: two tenures separated by one released cycle
        do_reset("s2");
        s = $urandom_range(0, MSZ-1); d = $urandom_range(0, MSZ-1);
        set_ch(0, s, d, 6); mdl(0, s, d, 6); model_run(2'b01);
        pulse(2'b01);
        wait_idle("s2");
        cmp_logs("s2", 1);
        chk("s2/ngap", gap_log.size(), 1);
        if (gap_log.size() > 0) chk("s2/gap_len", gap_log[0], 1);
        chk("s2/done0", done_cnt[0], 1);

        // two channels contending: tenures alternate
        do_reset("s3");
        for (int c = 0; c < NCH; c++) begin
            s = $urandom_range(0, MSZ-1); d = $urandom_range(0, MSZ-1);
            set_ch(c, s, d, 8); mdl(c, s, d, 8);
        end
        model_run(2'b11);
        pulse(2'b11);
        wait_idle("s3");
        cmp_logs("s3", 1);
        chk("s3/ngap", gap_log.size(), 3);
        foreach (gap_log[i]) chk($sformatf("s3/gap%0d", i), gap_log[i], 1);
        chk("s3/done0", done_cnt[0], 1);
        chk("s3/done1", done_cnt[1], 1);

        // grant revoked during the third READ
        do_reset("s4");
        s = $urandom_range(0, MSZ-1); d = $urandom_range(0, MSZ-1);
        set_ch(0, s, d, 7); mdl(0, s, d, 7); model_run(2'b01);
        pulse(2'b01);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rd && rd_log.size() == 2) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("s4/third_read_timeout", int'(ok), 1);
        hlda_off = 1;
        tick();
        chk("s4/we_completes", int'(we), 1);
        chk("s4/we_addr", int'(AB), (d + 2) % MSZ);
        tick();
        chk("s4/hldr_drop", int'(HLDR), 0);
        repeat (5) tick();
        chk("s4/held_reads", rd_log.size(), 3);
        chk("s4/held_writes", wa_log.size(), 3);
        chk("s4/held_rd", int'(rd), 0);
        hlda_off = 0;
        wait_idle("s4");
        cmp_logs("s4", 0);
        chk("s4/done0", done_cnt[0], 1);

        // address wrap, then a zero-length start
        do_reset("s5");
        d = $urandom_range(0, MSZ-1);
        set_ch(1, 'hFE, d, 4); mdl(1, 'hFE, d, 4); model_run(2'b10);
        pulse(2'b10);
        wait_idle("s5");
        cmp_logs("s5", 1);
        for (int i = 0; i < 4; i++) if (i < rd_log.size()) chk($sformatf("s5/wrap%0d", i), rd_log[i], wrapx[i]);
        set_ch(0, $urandom_range(0, MSZ-1), $urandom_range(0, MSZ-1), 0);
        start = 2'b01;
        tick();
        start = '0;
        chk("s5/zero_done", int'(done), 1);
        chk("s5/zero_busy", int'(busy), 0);
        chk("s5/zero_hldr", int'(HLDR), 0);
        tick();
        chk("s5/zero_done_end", int'(done), 0);
        chk("s5/zero_hldr2", int'(HLDR), 0);
        tick();
        chk("s5/zero_noread", rd_log.size(), 4);

        // reset during the second WRITE of five, then a clean restart
        do_reset("s6");
        s = $urandom_range(0, MSZ-1); d = $urandom_range(1, MSZ-3);
        set_ch(0, s, d, 5);
        pulse(2'b01);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (we && wa_log.size() == 1) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("s6/second_write_timeout", int'(ok), 1);
        reset_n = 0;
        #1;
        chk_quiet("s6/abort");
        repeat (2) tick();
        chk("s6/no_done", done_cnt[0], 0);
        reset_n = 1;
        tick();
        clear_logs();
        s = $urandom_range(0, MSZ-1); d = $urandom_range(0, MSZ-1);
        set_ch(0, s, d, 3); mdl(0, s, d, 3); model_run(2'b01);
        pulse(2'b01);
        wait_idle("s6");
        cmp_logs("s6", 1);
        chk("s6/done0", done_cnt[0], 1);

        // start on busy channel ignored; start coinciding with done
        do_reset("s7");
        s = $urandom_range(0, MSZ-1); d = $urandom_range(0, MSZ-1);
        set_ch(0, s, d, 2); mdl(0, s, d, 2); model_run(2'b01);
        pulse(2'b01);
        set_ch(0, s ^ 'h55, d ^ 'h33, 9);
        pulse(2'b01);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (done[0]) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("s7/done_timeout", int'(ok), 1);
        s = $urandom_range(0, MSZ-1); d = $urandom_range(0, MSZ-1);
        set_ch(1, s, d, 3); mdl(1, s, d, 3);
        set_ch(0, $urandom_range(0, MSZ-1), $urandom_range(0, MSZ-1), 5);
        start = 2'b11;
        tick();
        start = '0;
        chk("s7/accept_mask", int'(busy), 2);
        model_run(2'b10);
        wait_idle("s7");
        cmp_logs("s7", 1);
        chk("s7/done0", done_cnt[0], 1);
        chk("s7/done1", done_cnt[1], 1);

        chk("rd_we_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
